state_seq_monitor: RTL
======================

// Module: state_seq_monitor
// PURPOSE
//  Receive-side checker for the 3-bit state sequence driven by state_convert (data[2:0]).
//  Samples the sequence and detects every step. Decodes the generator's direction:
//  M=1 ring 110>100>101>001>011>010, M=0 is the reverse ring.
//  Flags illegal transitions and stalled sequences. Counts steps for display/debug logic.
// PARAMETERS
//  TIMEOUT  24'd12500000  idle cycles with no step before stalled asserts (> one 12 MHz second)
//  CNT_W    8             width of step_cnt
// PORTS
//  clk         in   1      system clock, 12 MHz
//  CR          in   1      reset: synchronous, active-high
//  data_in     in   3      observed state word, synchronous to clk
//  step        out  1      1-cycle pulse: legal step accepted
//  mode        out  1      decoded direction: 1 = M=1 ring, 0 = M=0 ring
//  mode_valid  out  1      mode is determined
//  mode_flip   out  1      1-cycle pulse: a valid mode reversed
//  illegal     out  1      1-cycle pulse: illegal transition seen
//  err_sticky  out  1      set by illegal; cleared only by CR
//  step_cnt    out  CNT_W  count of legal steps; wraps
//  stalled     out  1      level: no change for TIMEOUT cycles
// BEHAVIOUR
//  Reset (CR high at posedge; wins over any simultaneous event):
//  - prev=3'b111, idle_cnt=0.
//  - step=illegal=mode_flip=0, mode=0, mode_valid=0, err_sticky=0, step_cnt=0, stalled=0.
//  Event: at each posedge, data_in != prev. prev<=data_in on every event. All outputs are
//  registered: an event sampled at edge k shows its outputs after edge k, i.e. during cycle k+1.
//  Transition classes (prev>data_in):
//  - ONE (M=1 only): 001>011, 010>110, 011>010, 100>101, 101>001, 110>100
//  - ZERO (M=0 only): 001>101, 010>011, 011>001, 100>110, 101>100, 110>010
//  - BOTH: 000>110, 111>000
//  - RESYNC: any x>111 (generator reset observed)
//  - ILLEGAL: every other change
//  Action by class:
//  - ONE/ZERO/BOTH: step=1, step_cnt+1 (all ones wraps to 0), idle_cnt=0.
//  - ONE/ZERO, mode_valid=1, new mode != mode: mode_flip=1.
//  - ONE/ZERO, all cases: mode<=class (1 for ONE, 0 for ZERO), mode_valid<=1.
//  - BOTH: mode and mode_valid unchanged.
//  - RESYNC: step=0, illegal=0, step_cnt held, mode_valid=0, idle_cnt=0, err_sticky unchanged.
//  - ILLEGAL: illegal=1, err_sticky=1, mode_valid=0, step=0, step_cnt held, idle_cnt=0.
//  - No event: pulses are 0; idle_cnt increments, saturating at TIMEOUT.
//  stalled = (idle_cnt == TIMEOUT):
//  - rises TIMEOUT cycles after the last event
//  - clears in the cycle after the next event of any class
//  Pulses never exceed one cycle. Back-to-back events on consecutive cycles are each processed.
// TESTING
//  - Reset; 111,000,110,100,101,001 at 4-cycle spacing -> 5 step pulses, step_cnt=5;
//    mode_valid=1, mode=1 after 110>100; illegal never set.
//  - Continue from 001: 101,100 -> mode=0, one mode_flip pulse on 001>101, step_cnt=7.
//  - From 110, drive 101 -> illegal pulse, err_sticky=1, mode_valid=0, step_cnt unchanged.
//  - TIMEOUT=16: hold data_in 20 cycles -> stalled high from cycle 16 after last event;
//    low after the next change.
//  - Mid-run drive 111 -> no illegal, mode_valid=0; CR high with a change at same edge -> reset values.
//  - CNT_W=4: 16 legal steps -> step_cnt wraps to 0, no spurious flags.

Source files
------------

// File: rtl/state_seq_monitor.sv
// Receive-side checker for the 3-bit state_convert ring: classifies each change of
// data_in, decodes ring direction, flags illegal steps and stalls, counts legal steps.
module state_seq_monitor #(
  parameter logic [23:0] TIMEOUT = 24'd12500000,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             CR,
  input  logic [2:0]       data_in,
  output logic             step,
  output logic             mode,
  output logic             mode_valid,
  output logic             mode_flip,
  output logic             illegal,
  output logic             err_sticky,
  output logic [CNT_W-1:0] step_cnt,
  output logic             stalled
);

  typedef enum logic [2:0] {
    C_NONE, C_ONE, C_ZERO, C_BOTH, C_RESYNC, C_ILL
  } cls_e;

  logic [2:0]  prev;
  logic [23:0] idle_cnt;
  cls_e        cls;

  // Transition class of the word sampled at this edge relative to the last one
  always_comb begin
    cls = C_NONE;
    if (data_in != prev) begin
      if (data_in == 3'b111) cls = C_RESYNC;
      else begin
        case ({prev, data_in})
          6'b001_011, 6'b010_110, 6'b011_010,
          6'b100_101, 6'b101_001, 6'b110_100: cls = C_ONE;
          6'b001_101, 6'b010_011, 6'b011_001,
          6'b100_110, 6'b101_100, 6'b110_010: cls = C_ZERO;
          6'b000_110, 6'b111_000:             cls = C_BOTH;
          default:                            cls = C_ILL;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (CR) begin
      prev       <= 3'b111;
      idle_cnt   <= '0;
      step       <= 1'b0;
      illegal    <= 1'b0;
      mode_flip  <= 1'b0;
      mode       <= 1'b0;
      mode_valid <= 1'b0;
      err_sticky <= 1'b0;
      step_cnt   <= '0;
    end else begin
      prev      <= data_in;
      step      <= 1'b0;
      illegal   <= 1'b0;
      mode_flip <= 1'b0;
      case (cls)
        C_NONE: begin
          if (idle_cnt != TIMEOUT) idle_cnt <= idle_cnt + 24'd1;
        end
        C_ONE, C_ZERO: begin
          step       <= 1'b1;
          step_cnt   <= step_cnt + 1'b1;
          idle_cnt   <= '0;
          if (mode_valid && (mode != (cls == C_ONE))) mode_flip <= 1'b1;
          mode       <= (cls == C_ONE);
          mode_valid <= 1'b1;
        end
        C_BOTH: begin
          step     <= 1'b1;
          step_cnt <= step_cnt + 1'b1;
          idle_cnt <= '0;
        end
        C_RESYNC: begin
          mode_valid <= 1'b0;
          idle_cnt   <= '0;
        end
        default: begin
          illegal    <= 1'b1;
          err_sticky <= 1'b1;
          mode_valid <= 1'b0;
          idle_cnt   <= '0;
        end
      endcase
    end
  end

  assign stalled = (idle_cnt == TIMEOUT);

endmodule
